mmio_keysw_dev: RTL

- Memory-mapped responder for the processor's KEY and SW inputs; it is the device side of the processor's I/O load/store interface.
- Synchronises and debounces the raw board inputs and holds the committed values in data registers.
- Flags change events in status/control registers with ready and overrun bits, and can raise an interrupt request.
- Sits on the data-memory bus beside data memory; reads are combinational, to match the single-cycle datapath.

---
 rtl/mmio_keysw_dev_if.sv | 21 ++
 rtl/mmio_keysw_dev.sv | 152 +++++++++++++++
 2 files changed

// File: rtl/mmio_keysw_dev_if.sv
// Load/store bus between the processor datapath and a memory-mapped device.
// The master drives the address, store data and strobes; the slave returns read data.
interface mmio_keysw_dev_if #(
  parameter int DBITS = 32
);
  logic [DBITS-1:0] abus;
  logic [DBITS-1:0] dbus_in;
  logic             we;
  logic             re;
  logic [DBITS-1:0] dbus_out;

  modport master (
    output abus, dbus_in, we, re,
    input  dbus_out
  );

  modport slave (
    input  abus, dbus_in, we, re,
    output dbus_out
  );
endinterface

// File: rtl/mmio_keysw_dev.sv
// KEY/SW memory-mapped device: 2-flop synchronisers, per-group debounce,
// data registers, ready/overrun status and an optional interrupt request.
// Optional feature macro: MMIO_KEYSW_IRQ_EN (interrupt-enable bits and irq).
module mmio_keysw_dev #(
  parameter int                DBITS           = 32,
  parameter logic [DBITS-1:0]  ADDR_KEY        = 32'hF0000010,
  parameter logic [DBITS-1:0]  ADDR_SW         = 32'hF0000014,
  parameter logic [DBITS-1:0]  ADDR_KCTRL      = 32'hF0000110,
  parameter logic [DBITS-1:0]  ADDR_SCTRL      = 32'hF0000114,
  parameter int                KEY_BITS        = 4,
  parameter int                SW_BITS         = 10,
  parameter int                DEBOUNCE_CYCLES = 100000
) (
  input  logic                clk,
  input  logic                reset,
  mmio_keysw_dev_if.slave     bus,
  input  logic [KEY_BITS-1:0] KEY,
  input  logic [SW_BITS-1:0]  SW,
  output logic                irq
);

  localparam int CNT_W = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [KEY_BITS-1:0] k_s1, k_s2, k_commit;
  logic [SW_BITS-1:0]  s_s1, s_s2, s_commit;
  logic [CNT_W-1:0]    k_cnt, s_cnt;
  logic                k_ready, k_ovr, s_ready, s_ovr;
  logic                k_ie, s_ie;

  // Commit fires only while the synchronised value differs, so every commit is a change.
  logic k_evt, s_evt;
  assign k_evt = (k_s2 != k_commit) && (k_cnt == CNT_LAST);
  assign s_evt = (s_s2 != s_commit) && (s_cnt == CNT_LAST);

  logic k_data_rd, s_data_rd, k_ctrl_wr, s_ctrl_wr;
  assign k_data_rd = bus.re && (bus.abus == ADDR_KEY);
  assign s_data_rd = bus.re && (bus.abus == ADDR_SW);
  assign k_ctrl_wr = bus.we && (bus.abus == ADDR_KCTRL);
  assign s_ctrl_wr = bus.we && (bus.abus == ADDR_SCTRL);

  // Only bits 2 and 8 of store data matter; the rest are deliberately dropped.
  logic unused_dbus;
  assign unused_dbus = ^bus.dbus_in;

  // Two-flop synchronisers for the raw board inputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      k_s1 <= '1;
      k_s2 <= '1;
      s_s1 <= '0;
      s_s2 <= '0;
    end else begin
      k_s1 <= KEY;
      k_s2 <= k_s1;
      s_s1 <= SW;
      s_s2 <= s_s1;
    end
  end

  // KEY debounce: count consecutive cycles of disagreement, commit at the last count.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      k_cnt    <= '0;
      k_commit <= '1;
    end else if (k_s2 == k_commit) begin
      k_cnt <= '0;
    end else if (k_evt) begin
      k_cnt    <= '0;
      k_commit <= k_s2;
    end else begin
      k_cnt <= k_cnt + 1'b1;
    end
  end

  // SW debounce: same scheme as the KEY group.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s_cnt    <= '0;
      s_commit <= '0;
    end else if (s_s2 == s_commit) begin
      s_cnt <= '0;
    end else if (s_evt) begin
      s_cnt    <= '0;
      s_commit <= s_s2;
    end else begin
      s_cnt <= s_cnt + 1'b1;
    end
  end

  // Ready/overrun status; a new event beats both a data load and an overrun clear.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      k_ready <= 1'b0;
      k_ovr   <= 1'b0;
      s_ready <= 1'b0;
      s_ovr   <= 1'b0;
    end else begin
      if (k_evt)          k_ready <= 1'b1;
      else if (k_data_rd) k_ready <= 1'b0;
      if (k_evt && k_ready && !k_data_rd)   k_ovr <= 1'b1;
      else if (k_ctrl_wr && !bus.dbus_in[2]) k_ovr <= 1'b0;

      if (s_evt)          s_ready <= 1'b1;
      else if (s_data_rd) s_ready <= 1'b0;
      if (s_evt && s_ready && !s_data_rd)   s_ovr <= 1'b1;
      else if (s_ctrl_wr && !bus.dbus_in[2]) s_ovr <= 1'b0;
    end
  end

`ifdef MMIO_KEYSW_IRQ_EN
  // Interrupt-enable bits loaded from bit 8 of a control-register store.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      k_ie <= 1'b0;
      s_ie <= 1'b0;
    end else begin
      if (k_ctrl_wr) k_ie <= bus.dbus_in[8];
      if (s_ctrl_wr) s_ie <= bus.dbus_in[8];
    end
  end

  // Registered interrupt request, one cycle behind its condition.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) irq <= 1'b0;
    else       irq <= (k_ready && k_ie) || (s_ready && s_ie);
  end
`else
  assign k_ie = 1'b0;
  assign s_ie = 1'b0;
  assign irq  = 1'b0;
`endif

  // Combinational read mux; unmapped addresses return zero.
  always_comb begin
    bus.dbus_out = '0;
    if (bus.abus == ADDR_KEY) begin
      bus.dbus_out[KEY_BITS-1:0] = ~k_commit;
    end else if (bus.abus == ADDR_SW) begin
      bus.dbus_out[SW_BITS-1:0] = s_commit;
    end else if (bus.abus == ADDR_KCTRL) begin
      bus.dbus_out[0] = k_ready;
      bus.dbus_out[2] = k_ovr;
      bus.dbus_out[8] = k_ie;
    end else if (bus.abus == ADDR_SCTRL) begin
      bus.dbus_out[0] = s_ready;
      bus.dbus_out[2] = s_ovr;
      bus.dbus_out[8] = s_ie;
    end
  end

endmodule
